// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Op codes match the ALU control decoder and the hazard unit.
// The state encoding is used by the sequencer FSM.
package muldiv_pkg;

  localparam logic [4:0] OP_MULT  = 5'b01111;
  localparam logic [4:0] OP_MULTU = 5'b10000;
  localparam logic [4:0] OP_DIV   = 5'b10001;
  localparam logic [4:0] OP_DIVU  = 5'b10010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_t;

  // True for the four codes this unit executes; anything else is not ours.
  function automatic logic is_valid_op(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Iterative mult/multu/div/divu sequencer; owns architectural HI/LO.
// Latency: WIDTH+1 edges from accepting start to result in HI/LO (done pulse).
// No backpressure: start while busy is dropped, the pipeline must stall on busy.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi_en,
  input  logic             mtlo_en,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             op_div;
  logic             op_signed;
  logic             sign_a;
  logic             sign_b;
  logic             div_zero;
  // acc: upper product half while multiplying, partial remainder while dividing
  logic [WIDTH-1:0] acc;
  // lsr: multiplier shifting out / dividend shifting out while quotient shifts in
  logic [WIDTH-1:0] lsr;
  // opb: multiplicand or divisor magnitude
  logic [WIDTH-1:0] opb;
  // original dividend, returned in HI on divide by zero
  logic [WIDTH-1:0] orig_a;

  logic             req_ok;
  logic             req_signed;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] lsr_nxt;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;

  assign busy = (state != IDLE);

  // Decode the incoming request and take operand magnitudes for signed ops.
  always_comb begin
    req_ok     = start && is_valid_op(op);
    req_signed = op_is_signed(op);
    abs_a      = a;
    abs_b      = b;
    if (req_signed && a[WIDTH-1]) abs_a = '0 - a;
    if (req_signed && b[WIDTH-1]) abs_b = '0 - b;
  end

  // One shift-add multiply step or one restoring divide step.
  always_comb begin
    add_sum   = {1'b0, acc} + (lsr[0] ? {1'b0, opb} : '0);
    div_shift = {acc, lsr[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    acc_nxt   = add_sum[WIDTH:1];
    lsr_nxt   = {add_sum[0], lsr[WIDTH-1:1]};
    if (op_div) begin
      if (!div_diff[WIDTH]) begin
        acc_nxt = div_diff[WIDTH-1:0];
        lsr_nxt = {lsr[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = div_shift[WIDTH-1:0];
        lsr_nxt = {lsr[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fixup of the unsigned magnitude results.
  always_comb begin
    prod    = {acc, lsr};
    mul_res = prod;
    quo_res = lsr;
    rem_res = acc;
    if (op_signed && (sign_a ^ sign_b)) begin
      mul_res = '0 - prod;
      quo_res = '0 - lsr;
    end
    if (op_signed && sign_a) rem_res = '0 - acc;
  end

  // Sequencer FSM plus HI/LO ownership.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_div    <= 1'b0;
      op_signed <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      div_zero  <= 1'b0;
      acc       <= '0;
      lsr       <= '0;
      opb       <= '0;
      orig_a    <= '0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi_en) hi <= wdata;
          if (mtlo_en) lo <= wdata;
          if (req_ok) begin
            op_div    <= op_is_div(op);
            op_signed <= req_signed;
            sign_a    <= a[WIDTH-1];
            sign_b    <= b[WIDTH-1];
            div_zero  <= (b == '0);
            orig_a    <= a;
            acc       <= '0;
            lsr       <= abs_a;
            opb       <= abs_b;
            cnt       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          lsr <= lsr_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= FIXUP;
        end
        FIXUP: begin
          if (!op_div) begin
            hi <= mul_res[2*WIDTH-1:WIDTH];
            lo <= mul_res[WIDTH-1:0];
          end else if (div_zero) begin
            hi <= orig_a;
            lo <= '1;
          end else begin
            hi <= rem_res;
            lo <= quo_res;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with hand-computed HI/LO results.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi_en;
  logic        mtlo_en;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .mthi_en (mthi_en),
    .mtlo_en (mtlo_en),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request at the negedge; return #1 after the accepting edge.
  task automatic launch(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    int edges;
    int busy_cnt;
    logic got;
    launch(o, x, y);
    edges = 0;
    got = 1'b0;
    busy_cnt = busy ? 1 : 0;
    while (!got && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) got = 1'b1;
      else if (busy) busy_cnt++;
    end
    check({tag, "_lat"}, 32'(edges), 32'd33);
    check({tag, "_busy"}, 32'(busy_cnt), 32'd33);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    mthi_en = 1'b0; mtlo_en = 1'b0; wdata = '0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    #20;
    @(negedge clk);
    reset = 1'b0;

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",      OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3);
    run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    run_op("divu_zero", OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);

    // Unknown op code must not start anything.
    launch(5'b00010, 32'd1, 32'd2);
    check("badop_busy0", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("badop_busy1", {31'd0, busy}, 32'd0);
    check("badop_hi", hi, 32'd5);
    check("badop_lo", lo, 32'hFFFF_FFFF);

    // Second start and mthi while busy are both ignored.
    launch(OP_MULT, 32'd6, 32'd7);
    dcnt = 0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
      if (e == 5) begin
        op = OP_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
      end
      if (e == 6) start = 1'b0;
      if (e == 8) begin
        mthi_en = 1'b1; wdata = 32'h0000_1234;
      end
      if (e == 9) begin
        check("mthi_busy_hi", hi, 32'd5);
        mthi_en = 1'b0;
      end
    end
    check("dbl_done_cnt", 32'(dcnt), 32'd1);
    check("dbl_hi", hi, 32'd0);
    check("dbl_lo", lo, 32'd42);

    // mthi and mtlo together in IDLE write both registers.
    @(negedge clk);
    mthi_en = 1'b1; mtlo_en = 1'b1; wdata = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    mthi_en = 1'b0; mtlo_en = 1'b0;
    check("mtboth_hi", hi, 32'h5555_AAAA);
    check("mtboth_lo", lo, 32'h5555_AAAA);

    // Asynchronous reset in the middle of RUN.
    launch(OP_DIVU, 32'd100, 32'd3);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    check("midrst_no_done", 32'(dcnt), 32'd0);
    check("midrst_idle", {31'd0, busy}, 32'd0);

    // mtlo in IDLE lands on the next edge.
    @(negedge clk);
    mtlo_en = 1'b1; wdata = 32'h0000_ABCD;
    check("mtlo_before", lo, 32'd0);
    @(posedge clk);
    #1;
    mtlo_en = 1'b0;
    check("mtlo_lo", lo, 32'h0000_ABCD);
    check("mtlo_hi", hi, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
